// File: rtl/ap_set_driver.sv
// rtl/ap_set_driver.sv - APSet/APSel initiator: command FIFO, one-cycle APSet pulse, readback confirm with retry
module ap_set_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1,
    parameter int MAX_RETRY  = 2,
    parameter int SKIP_SAME  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_sel,
    output logic       req_ready,
    output logic [3:0] APSet,
    input  logic [3:0] APSel_fb,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [2:0]    SETTLE_C  = 3'(SETTLE);
    localparam logic [2:0]    RETRY_C   = 3'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    tgt_q, tgt_d;
    logic [2:0]    retry_q, retry_d;
    logic [2:0]    wait_q, wait_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [3:0]    apset_q;
    logic          done_q, err_q;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop;

    assign req_ready = (count_q != DEPTH_C);
    assign push      = req_valid && req_ready;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign APSet     = apset_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        retry_d    = retry_q;
        wait_d     = wait_q;
        err_code_d = err_code_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    tgt_d   = mem_q[rd_ptr_q];
                    retry_d = '0;
                    if (tgt_d == 4'd15) begin
                        state_d    = S_ERR;
                        err_code_d = 2'b01;
                    end else if ((SKIP_SAME != 0) && (APSel_fb == tgt_d)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wait_d  = SETTLE_C;
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_CHECK;
                else              wait_d  = wait_q - 3'd1;
            end
            S_CHECK: begin
                if (APSel_fb == tgt_q) begin
                    state_d = S_DONE;
                end else if (retry_q < RETRY_C) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_ISSUE;
                end else begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tgt_q      <= '0;
            retry_q    <= '0;
            wait_q     <= '0;
            err_code_q <= '0;
            apset_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            retry_q    <= retry_d;
            wait_q     <= wait_d;
            err_code_q <= err_code_d;
            apset_q    <= (state_d == S_ISSUE) ? tgt_d + 4'd1 : 4'd0;
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_sel;
    end
endmodule

// File: tb/tb_ap_set_driver.sv
// tb/tb_ap_set_driver.sv - scoreboard bench for ap_set_driver with a behavioural AP register model
module tb_ap_set_driver;
    localparam int SETTLE    = 1;
    localparam int MAX_RETRY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_sel = '0;
    logic       req_ready;
    logic [3:0] APSet;
    logic [3:0] APSel_fb = '0;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic       stuck = 1'b0;

    int total = 0;
    int bad   = 0;
    int completions = 0;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        int         pulses;
        logic [3:0] apset;
    } exp_t;
    exp_t exp_q[$];
    logic [3:0] model_ap = '0;

    ap_set_driver #(.FIFO_DEPTH(4), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY), .SKIP_SAME(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .APSet(APSet), .APSel_fb(APSel_fb), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // AP register: latches APSet-1 on the edge after a nonzero APSet, unless stuck.
    always @(posedge clk) begin
        if (stuck)            APSel_fb <= 4'd3;
        else if (APSet != 0)  APSel_fb <= APSet - 4'd1;
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    // Reference outcome from the command rules, given the AP value it will see.
    task automatic model_enqueue(input logic [3:0] s);
        exp_t e;
        e.is_err = 0; e.code = 2'b00; e.pulses = 0; e.apset = s + 4'd1;
        if (s == 4'd15) begin
            e.is_err = 1; e.code = 2'b01;
        end else if (model_ap == s) begin
            e.pulses = 0;
        end else if (stuck && s != 4'd3) begin
            e.is_err = 1; e.code = 2'b10; e.pulses = MAX_RETRY + 1;
        end else begin
            e.pulses = 1;
            model_ap = s;
        end
        exp_q.push_back(e);
    endtask

    int   pulse_cnt = 0;
    int   since_pulse = 0;
    logic [3:0] last_val = '0;
    logic [3:0] prev_apset = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pulse_cnt = 0; since_pulse = 0; prev_apset = '0;
        end else begin
            if (APSet != 0) begin
                pulse_cnt++;
                since_pulse = 0;
                last_val = APSet;
                if (prev_apset != 0) chk("apset_one_cycle", prev_apset, 0);
            end else begin
                since_pulse++;
            end
            prev_apset = APSet;
            if (done || err) begin
                completions++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind_err", err, e.is_err);
                    chk("kind_done", done, !e.is_err);
                    if (e.is_err) chk("err_code", err_code, e.code);
                    chk("apset_pulses", pulse_cnt, e.pulses);
                    if (e.pulses > 0) chk("apset_value", last_val, e.apset);
                    if (!e.is_err && e.pulses > 0) chk("done_latency", since_pulse, 3 + SETTLE);
                end
                pulse_cnt = 0;
            end
        end
    end

    task automatic push(input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("push_timeout", 1, 0);
        req_valid = 1'b1;
        req_sel   = s;
        model_enqueue(s);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_q.size() != 0) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int saved;
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_apset", APSet, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_err_code", err_code, 0);
        rst = 1'b0;

        push(4'd5);
        wait_idle();
        chk("apsel_after_5", APSel_fb, 5);

        push(4'd15);
        push(4'd1);
        wait_idle();
        chk("err_code_held", err_code, 1);

        stuck = 1'b1;
        @(negedge clk);
        model_ap = 4'd3;
        push(4'd7);
        wait_idle();
        stuck = 1'b0;
        chk("err_code_retry", err_code, 2);

        push(4'd9);
        wait_idle();
        push(4'd9);
        for (int i = 0; i < 5; i++) push(4'(2 + 2 * i));
        @(negedge clk);
        chk("req_ready_full", req_ready, 0);
        wait_idle();
        chk("apsel_after_burst", APSel_fb, 10);

        for (int i = 0; i < 30; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) s = model_ap;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(s);
        end
        wait_idle();
        chk("apsel_after_random", APSel_fb, model_ap);

        push(4'd3 == model_ap ? 4'd4 : 4'd3);
        n = 0;
        while (APSet == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("apset_seen_before_reset", APSet != 0, 1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_ap = APSel_fb;
        saved = completions;
        @(negedge clk);
        chk("abort_apset", APSet, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_pulse", completions, saved);

        push(4'd11);
        wait_idle();
        chk("post_abort_apsel", APSel_fb, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
